// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage RV32 pipeline.
// Interrupt entry drains EX/MEM/WB, then redirects to mtvec and pulses irq_take_o for the mepc capture.
module pipeline_stall_ctrl #(
  parameter int XLEN      = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hazard_i,
  input  logic            im_stall_i,
  input  logic            dm_stall_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            irq_pending_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            pc_write_o,
  output logic            if_id_write_o,
  output logic            id_ex_write_o,
  output logic            ex_mem_write_o,
  output logic            mem_wb_write_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            pc_redirect_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            irq_take_o,
  output logic [XLEN-1:0] irq_epc_o,
  output logic            busy_o
);

  localparam int CW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {RUN, DRAIN, ENTER} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
  logic [XLEN-1:0] epc, epc_nxt;
  logic            mem_stall;
  logic            irq_accept;

  assign mem_stall  = im_stall_i | dm_stall_i;
  assign irq_accept = irq_pending_i & id_valid_i & ~hazard_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      epc       <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      epc       <= epc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    epc_nxt       = epc;
    case (state)
      RUN: begin
        if (!mem_stall && !ex_redirect_i && irq_accept) begin
          epc_nxt       = id_pc_i;
          drain_cnt_nxt = CW'(DRAIN_CYC);
          state_nxt     = DRAIN;
        end
      end
      DRAIN: begin
        // An older branch resolving during the drain owns the return address.
        if (ex_redirect_i) epc_nxt = ex_target_i;
        if (!mem_stall) begin
          if (drain_cnt == CW'(1)) begin
            drain_cnt_nxt = '0;
            state_nxt     = ENTER;
          end else begin
            drain_cnt_nxt = drain_cnt - CW'(1);
          end
        end
      end
      ENTER: begin
        if (!im_stall_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    id_ex_write_o  = 1'b0;
    ex_mem_write_o = 1'b0;
    mem_wb_write_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    pc_redirect_o  = 1'b0;
    pc_target_o    = ex_target_i;
    irq_take_o     = 1'b0;
    irq_epc_o      = epc;
    busy_o         = 1'b0;
    if (rst) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            // everything frozen; a pending redirect is re-presented after the stall
          end else if (ex_redirect_i) begin
            pc_write_o     = 1'b1;
            if_id_write_o  = 1'b1;
            id_ex_write_o  = 1'b1;
            ex_mem_write_o = 1'b1;
            mem_wb_write_o = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            pc_redirect_o  = 1'b1;
          end else if (irq_accept) begin
            if_id_write_o  = 1'b1;
            id_ex_write_o  = 1'b1;
            ex_mem_write_o = 1'b1;
            mem_wb_write_o = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
          end else if (hazard_i) begin
            id_ex_write_o  = 1'b1;
            ex_mem_write_o = 1'b1;
            mem_wb_write_o = 1'b1;
            id_ex_flush_o  = 1'b1;
          end else begin
            pc_write_o     = 1'b1;
            if_id_write_o  = 1'b1;
            id_ex_write_o  = 1'b1;
            ex_mem_write_o = 1'b1;
            mem_wb_write_o = 1'b1;
          end
        end
        DRAIN: begin
          busy_o        = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (!mem_stall) begin
            if_id_write_o  = 1'b1;
            id_ex_write_o  = 1'b1;
            ex_mem_write_o = 1'b1;
            mem_wb_write_o = 1'b1;
          end
        end
        ENTER: begin
          busy_o        = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          pc_target_o   = trap_vec_i;
          if (!im_stall_i) begin
            pc_write_o     = 1'b1;
            if_id_write_o  = 1'b1;
            id_ex_write_o  = 1'b1;
            ex_mem_write_o = 1'b1;
            mem_wb_write_o = 1'b1;
            pc_redirect_o  = 1'b1;
            irq_take_o     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: RUN-state vector table, interrupt-entry sequences,
// and randomized traffic against a step-counting reference model.
module tb_pipeline_stall_ctrl;

  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard, im_stall, dm_stall, ex_redirect, id_valid, irq_pending;
  logic [31:0] ex_target, id_pc, trap_vec;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic        if_id_flush, id_ex_flush, pc_redirect, irq_take, busy;
  logic [31:0] pc_target, irq_epc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.XLEN(32), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst),
    .hazard_i(hazard), .im_stall_i(im_stall), .dm_stall_i(dm_stall),
    .ex_redirect_i(ex_redirect), .ex_target_i(ex_target),
    .id_valid_i(id_valid), .id_pc_i(id_pc),
    .irq_pending_i(irq_pending), .trap_vec_i(trap_vec),
    .pc_write_o(pc_write), .if_id_write_o(if_id_write), .id_ex_write_o(id_ex_write),
    .ex_mem_write_o(ex_mem_write), .mem_wb_write_o(mem_wb_write),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .pc_redirect_o(pc_redirect), .pc_target_o(pc_target),
    .irq_take_o(irq_take), .irq_epc_o(irq_epc), .busy_o(busy)
  );

  // {pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, redirect, take, busy}
  function automatic logic [9:0] act_ctl();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
            if_id_flush, id_ex_flush, pc_redirect, irq_take, busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hazard = 0; im_stall = 0; dm_stall = 0; ex_redirect = 0; id_valid = 0; irq_pending = 0;
    ex_target = 32'h0; id_pc = 32'h0; trap_vec = 32'h800;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Reference model: entry progress as number of unstalled drain cycles completed
  // (-1 = normal running, 0..DC-1 = draining, DC = waiting to redirect to the trap vector).
  int          m_step;
  logic [31:0] m_epc;

  function automatic logic [9:0] model_ctl(int st);
    logic stall;
    stall = im_stall | dm_stall;
    if (rst) return 10'b00000_11_000;
    if (st < 0) begin
      if (stall) return 10'b00000_00_000;
      if (ex_redirect) return 10'b11111_11_100;
      if (irq_pending && id_valid && !hazard) return 10'b01111_11_000;
      if (hazard) return 10'b00111_01_000;
      return 10'b11111_00_000;
    end
    if (st < DC) return stall ? 10'b00000_11_001 : 10'b01111_11_001;
    return im_stall ? 10'b00000_11_001 : 10'b11111_11_111;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_step = -1;
      m_epc  = 0;
    end else if (m_step < 0) begin
      if (!(im_stall | dm_stall) && !ex_redirect && irq_pending && id_valid && !hazard) begin
        m_step = 0;
        m_epc  = id_pc;
      end
    end else if (m_step < DC) begin
      if (ex_redirect) m_epc = ex_target;
      if (!(im_stall | dm_stall)) m_step++;
    end else if (!im_stall) begin
      m_step = -1;
    end
  endtask

  typedef struct {
    logic        haz, im, dm, rd, idv, irq;
    logic [31:0] tgt;
    logic [9:0]  ctl;
  } vec_t;

  vec_t vecs[9];

  // Interrupt entry scenario: irq with id_pc=0x40 on cycle 0, trap vector 0x800.
  task automatic run_irq(input int dm_from, input int dm_len, input int im_from, input int im_len,
                         input int redir_at, input int rst_at,
                         output int take_cyc, output int takes, output logic [31:0] ep,
                         output logic [31:0] tg, output logic [15:0] busy_v);
    take_cyc = -1; takes = 0; ep = 0; tg = 0; busy_v = 0;
    for (int k = 0; k < 16; k++) begin
      irq_pending = (k == 0);
      id_valid    = (k == 0);
      id_pc       = 32'h40;
      trap_vec    = 32'h800;
      hazard      = 0;
      dm_stall    = (k >= dm_from) && (k < dm_from + dm_len);
      im_stall    = (k >= im_from) && (k < im_from + im_len);
      ex_redirect = (k == redir_at);
      ex_target   = 32'h200;
      rst         = (k == rst_at);
      @(negedge clk);
      busy_v[k] = busy;
      if (irq_take) begin
        takes++;
        if (take_cyc < 0) begin
          take_cyc = k;
          ep = irq_epc;
          tg = pc_target;
        end
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    int          tc, tk;
    logic [31:0] ep, tg;
    logic [15:0] bv;
    logic [9:0]  e;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 32'h0,   10'b11111_00_000};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 32'h0,   10'b00111_01_000};
    vecs[2] = '{1, 0, 0, 1, 0, 0, 32'h100, 10'b11111_11_100};
    vecs[3] = '{0, 0, 1, 1, 0, 0, 32'h100, 10'b00000_00_000};
    vecs[4] = '{0, 1, 0, 0, 1, 1, 32'h0,   10'b00000_00_000};
    vecs[5] = '{0, 0, 0, 0, 1, 1, 32'h0,   10'b01111_11_000};
    vecs[6] = '{1, 0, 0, 0, 1, 1, 32'h0,   10'b00111_01_000};
    vecs[7] = '{0, 0, 0, 0, 0, 1, 32'h0,   10'b11111_00_000};
    vecs[8] = '{0, 0, 0, 1, 1, 1, 32'h300, 10'b11111_11_100};

    idle_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    chk("reset_ctl", 32'(act_ctl()), 32'(10'b00000_11_000));
    tick();
    rst = 0;

    foreach (vecs[i]) begin
      hazard = vecs[i].haz; im_stall = vecs[i].im; dm_stall = vecs[i].dm;
      ex_redirect = vecs[i].rd; id_valid = vecs[i].idv; irq_pending = vecs[i].irq;
      ex_target = vecs[i].tgt; id_pc = 32'h44;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(act_ctl()), 32'(vecs[i].ctl));
      if (vecs[i].ctl[2]) chk($sformatf("vec%0d_tgt", i), pc_target, vecs[i].tgt);
      tick();
      do_reset();
    end

    // One-cycle hazard, then full flow resumes
    hazard = 1;
    @(negedge clk);
    chk("haz_cycle", 32'(act_ctl()), 32'(10'b00111_01_000));
    tick();
    hazard = 0;
    @(negedge clk);
    chk("haz_after", 32'(act_ctl()), 32'(10'b11111_00_000));
    tick();

    // Redirect held behind a 4-cycle data stall
    ex_redirect = 1; ex_target = 32'h100;
    for (int k = 0; k < 5; k++) begin
      dm_stall = (k < 4);
      @(negedge clk);
      chk($sformatf("rd_dm_c%0d", k), 32'(pc_redirect), (k < 4) ? 32'd0 : 32'd1);
      if (k == 4) chk("rd_dm_tgt", pc_target, 32'h100);
      tick();
    end
    idle_inputs();

    run_irq(99, 0, 99, 0, 99, 99, tc, tk, ep, tg, bv);
    chk("irq_take_cyc", tc, 4);
    chk("irq_take_cnt", tk, 1);
    chk("irq_epc", ep, 32'h40);
    chk("irq_target", tg, 32'h800);
    chk("irq_busy", 32'(bv[5:0]), 32'(6'b011110));

    run_irq(2, 2, 99, 0, 99, 99, tc, tk, ep, tg, bv);
    chk("irq_dm_take_cyc", tc, 6);
    chk("irq_dm_take_cnt", tk, 1);

    run_irq(99, 0, 99, 0, 1, 99, tc, tk, ep, tg, bv);
    chk("irq_rd_epc", ep, 32'h200);
    chk("irq_rd_take_cyc", tc, 4);

    run_irq(99, 0, 4, 2, 99, 99, tc, tk, ep, tg, bv);
    chk("irq_im_enter_cyc", tc, 6);
    chk("irq_im_enter_cnt", tk, 1);

    run_irq(99, 0, 99, 0, 99, 2, tc, tk, ep, tg, bv);
    chk("irq_rst_busy_pre", 32'(bv[1]), 32'd1);
    chk("irq_rst_busy_post", 32'(bv[3]), 32'd0);
    chk("irq_rst_takes", tk, 0);

    // Randomized traffic against the reference model
    do_reset();
    m_step = -1;
    m_epc  = 0;
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(99) == 0);
      hazard      = ($urandom_range(99) < 20);
      im_stall    = ($urandom_range(99) < 12);
      dm_stall    = ($urandom_range(99) < 12);
      ex_redirect = ($urandom_range(99) < 15);
      id_valid    = ($urandom_range(99) < 80);
      irq_pending = ($urandom_range(99) < 30);
      ex_target   = {$urandom_range(32'hffff), 2'b00} & 32'h3fffc;
      id_pc       = $urandom & 32'hfffffffc;
      trap_vec    = 32'h800 | ($urandom_range(15) << 8);
      @(negedge clk);
      e = model_ctl(m_step);
      chk($sformatf("rnd%0d_ctl", i), 32'(act_ctl()), 32'(e));
      if (e[2]) chk($sformatf("rnd%0d_tgt", i), pc_target, (m_step < 0) ? ex_target : trap_vec);
      if (e[1]) chk($sformatf("rnd%0d_epc", i), irq_epc, m_epc);
      @(posedge clk);
      model_update();
      #1;
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
